// File: rtl/any1_issue_ctrl.sv
// Issue controller: parks scheduler selections in per-class slots, hands them to the
// execution units over valid/ready, and sequences the non-pipelined MDV unit.
//
// MDV FSM states
//   state      | meaning
//   MDV_IDLE   | no MDV op outstanding; class-3 selections may be accepted
//   MDV_ISSUE  | op presented to the unit for exactly one cycle (no ready)
//   MDV_BUSY   | unit working, waiting for mdv_done_i
//   MDV_SQUASH | op was flushed; result discarded when mdv_done_i arrives
module any1_issue_ctrl #(
  parameter  int ROB_ENTRIES = 64,
  localparam int ID_W        = $clog2(ROB_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W:0]   sel_i,
  input  logic [1:0]      sel_cls_i,
  input  logic            flush_i,
  input  logic            alu_rdy_i,
  input  logic            mem_rdy_i,
  input  logic            fc_rdy_i,
  input  logic            mdv_done_i,
  output logic            alu_v_o,
  output logic            mem_v_o,
  output logic            fc_v_o,
  output logic            mdv_v_o,
  output logic [ID_W-1:0] alu_id_o,
  output logic [ID_W-1:0] mem_id_o,
  output logic [ID_W-1:0] fc_id_o,
  output logic [ID_W-1:0] mdv_id_o,
  output logic            acc_o,
  output logic            out_v_o,
  output logic [ID_W-1:0] out_id_o,
  output logic            mdv_squash_o,
  output logic [3:0]      busy_o
);

  typedef enum logic [1:0] {
    MDV_IDLE   = 2'd0,
    MDV_ISSUE  = 2'd1,
    MDV_BUSY   = 2'd2,
    MDV_SQUASH = 2'd3
  } mdv_state_t;

  localparam logic [1:0] CLS_MDV = 2'd3;

  mdv_state_t        mdv_state;
  mdv_state_t        mdv_next;
  logic [ID_W-1:0]   mdv_id;
  logic              mdv_squash;

  logic [2:0]        slot_full;
  logic [ID_W-1:0]   slot_id [3];
  logic [2:0]        unit_rdy;

  logic [ID_W-1:0]   sel_id;
  logic              sel_vld;
  logic              dup;
  logic              room;
  logic              acc;
  logic              mdv_acc;

  assign unit_rdy = {fc_rdy_i, mem_rdy_i, alu_rdy_i};

  // A selection matching any in-flight ID is dropped so it is never issued twice;
  // a draining slot still counts as in flight this cycle.
  always_comb begin
    sel_id  = sel_i[ID_W-1:0];
    sel_vld = !sel_i[ID_W];
    dup     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (slot_full[i] && (slot_id[i] == sel_id)) dup = 1'b1;
    end
    if ((mdv_state != MDV_IDLE) && (mdv_id == sel_id)) dup = 1'b1;
    case (sel_cls_i)
      2'd0:    room = !slot_full[0] || unit_rdy[0];
      2'd1:    room = !slot_full[1] || unit_rdy[1];
      2'd2:    room = !slot_full[2] || unit_rdy[2];
      default: room = (mdv_state == MDV_IDLE);
    endcase
    acc     = !rst && sel_vld && !flush_i && !dup && room;
    mdv_acc = acc && (sel_cls_i == CLS_MDV);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        slot_full[i] <= 1'b0;
        slot_id[i]   <= '0;
      end else if (flush_i) begin
        slot_full[i] <= 1'b0;
      end else if (acc && (sel_cls_i == 2'(i))) begin
        slot_full[i] <= 1'b1;
        slot_id[i]   <= sel_id;
      end else if (slot_full[i] && unit_rdy[i]) begin
        slot_full[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_o  <= 1'b0;
      out_id_o <= '0;
    end else begin
      out_v_o <= acc;
      if (acc) out_id_o <= sel_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdv_state <= MDV_IDLE;
      mdv_id    <= '0;
    end else begin
      mdv_state <= mdv_next;
      if (mdv_acc) mdv_id <= sel_id;
    end
  end

  // Done during ISSUE cannot happen (minimum occupancy), so ISSUE ignores it.
  always_comb begin
    mdv_next   = mdv_state;
    mdv_squash = 1'b0;
    case (mdv_state)
      MDV_IDLE: begin
        if (mdv_acc) mdv_next = MDV_ISSUE;
      end
      MDV_ISSUE: begin
        mdv_next = flush_i ? MDV_SQUASH : MDV_BUSY;
      end
      MDV_BUSY: begin
        if (mdv_done_i) begin
          mdv_next   = MDV_IDLE;
          mdv_squash = flush_i;
        end else if (flush_i) begin
          mdv_next = MDV_SQUASH;
        end
      end
      MDV_SQUASH: begin
        mdv_squash = 1'b1;
        if (mdv_done_i) mdv_next = MDV_IDLE;
      end
      default: mdv_next = MDV_IDLE;
    endcase
  end

  assign acc_o        = acc;
  assign mdv_squash_o = mdv_squash && !rst;

  assign alu_v_o  = slot_full[0];
  assign mem_v_o  = slot_full[1];
  assign fc_v_o   = slot_full[2];
  assign mdv_v_o  = (mdv_state == MDV_ISSUE);
  assign alu_id_o = slot_id[0];
  assign mem_id_o = slot_id[1];
  assign fc_id_o  = slot_id[2];
  assign mdv_id_o = mdv_id;
  assign busy_o   = {(mdv_state != MDV_IDLE), slot_full};

endmodule
